// File: rtl/mem_stage.sv
// MEM stage of the five-stage RISC-V pipeline: branch resolution, word data memory
// with configurable access latency, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] EX_MEM_NPC,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        mem_stall,
  output logic [1:0]  wb_ctlout,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg
);

  localparam int AW = $clog2(DEPTH);
  localparam bit MULTI = (LATENCY > 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          access;

  assign idx    = alu_result[AW+1:2];
  assign access = memread | memwrite;

  // Stall covers every access cycle except the last one, where cnt has counted down to 1.
  assign mem_stall = ((state == BUSY) && (cnt > 4'd1)) ||
                     ((state == IDLE) && access && MULTI);

  assign pcsrc         = ~rst & branch & zero;
  assign branch_target = EX_MEM_NPC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access && MULTI) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        default: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
      endcase
    end
  end

  // Memory array has no reset so it maps onto block RAM; a reset edge aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && !mem_stall && memwrite) mem[idx] <= rdata2out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ctlout      <= 2'b00;
      read_data      <= 32'd0;
      mem_alu_result <= 32'd0;
      mem_write_reg  <= 5'd0;
    end else if (!mem_stall) begin
      wb_ctlout      <= wb_ctl;
      mem_alu_result <= alu_result;
      mem_write_reg  <= five_bit_muxout;
      read_data      <= memread ? mem[idx] : 32'd0;
    end else begin
      wb_ctlout <= 2'b00;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance with single-cycle memory, one with LATENCY=4,
// both checked every cycle against a transaction-level model plus directed checks.
module tb_mem_stage;

  typedef struct packed {
    logic        rst;
    logic [1:0]  wb_ctl;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [31:0] npc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } stim_t;

  logic  clk = 1'b0;
  stim_t s1, s4;
  int    test_count = 0;
  int    fail_count = 0;
  bit    check_en = 1'b0;

  logic        o_pcsrc[2], o_stall[2];
  logic [31:0] o_target[2], o_rdata[2], o_alu[2];
  logic [1:0]  o_wb[2];
  logic [4:0]  o_reg[2];

  logic [31:0] m_mem [2][256];
  int          m_age [2];
  logic [1:0]  e_wb  [2];
  logic [31:0] e_rd  [2];
  logic [31:0] e_alu [2];
  logic [4:0]  e_reg [2];

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .rst(s1.rst), .wb_ctl(s1.wb_ctl), .branch(s1.branch),
    .memread(s1.memread), .memwrite(s1.memwrite), .zero(s1.zero),
    .EX_MEM_NPC(s1.npc), .alu_result(s1.alu), .rdata2out(s1.wdata),
    .five_bit_muxout(s1.rd), .pcsrc(o_pcsrc[0]), .branch_target(o_target[0]),
    .mem_stall(o_stall[0]), .wb_ctlout(o_wb[0]), .read_data(o_rdata[0]),
    .mem_alu_result(o_alu[0]), .mem_write_reg(o_reg[0])
  );

  mem_stage #(.DEPTH(256), .LATENCY(4)) u4 (
    .clk(clk), .rst(s4.rst), .wb_ctl(s4.wb_ctl), .branch(s4.branch),
    .memread(s4.memread), .memwrite(s4.memwrite), .zero(s4.zero),
    .EX_MEM_NPC(s4.npc), .alu_result(s4.alu), .rdata2out(s4.wdata),
    .five_bit_muxout(s4.rd), .pcsrc(o_pcsrc[1]), .branch_target(o_target[1]),
    .mem_stall(o_stall[1]), .wb_ctlout(o_wb[1]), .read_data(o_rdata[1]),
    .mem_alu_result(o_alu[1]), .mem_write_reg(o_reg[1])
  );

  function automatic stim_t idle_s();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t st(input logic [31:0] addr, input logic [31:0] data);
    stim_t s = '0;
    s.memwrite = 1'b1;
    s.alu      = addr;
    s.wdata    = data;
    return s;
  endfunction

  function automatic stim_t ld(input logic [31:0] addr, input logic [1:0] wb, input logic [4:0] rd);
    stim_t s = '0;
    s.memread = 1'b1;
    s.alu     = addr;
    s.wb_ctl  = wb;
    s.rd      = rd;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model: an access is held for LATENCY cycles; only the last one updates memory and MEM/WB.
  task automatic model_edge(input int k, input stim_t s, input int lat);
    int idx;
    idx = int'((s.alu / 32'd4) % 32'd256);
    if (s.rst) begin
      m_age[k] = 0;
      e_wb[k]  = 2'b00;
      e_rd[k]  = 32'd0;
      e_alu[k] = 32'd0;
      e_reg[k] = 5'd0;
    end else if ((s.memread || s.memwrite) && m_age[k] < lat - 1) begin
      m_age[k]++;
      e_wb[k] = 2'b00;
    end else begin
      e_rd[k] = s.memread ? m_mem[k][idx] : 32'd0;
      if (s.memwrite) m_mem[k][idx] = s.wdata;
      e_wb[k]  = s.wb_ctl;
      e_alu[k] = s.alu;
      e_reg[k] = s.rd;
      m_age[k] = 0;
    end
  endtask

  function automatic logic exp_stall(input int k, input stim_t s, input int lat);
    return (s.memread || s.memwrite) && (m_age[k] < lat - 1);
  endfunction

  always @(posedge clk) begin
    model_edge(0, s1, 1);
    model_edge(1, s4, 4);
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        stim_t s;
        int lat;
        s   = (k == 0) ? s1 : s4;
        lat = (k == 0) ? 1 : 4;
        checkOutput($sformatf("u%0d.mem_stall", lat), 32'(o_stall[k]), 32'(exp_stall(k, s, lat)));
        checkOutput($sformatf("u%0d.pcsrc", lat), 32'(o_pcsrc[k]), 32'(~s.rst & s.branch & s.zero));
        checkOutput($sformatf("u%0d.branch_target", lat), o_target[k], s.npc);
        checkOutput($sformatf("u%0d.wb_ctlout", lat), 32'(o_wb[k]), 32'(e_wb[k]));
        checkOutput($sformatf("u%0d.read_data", lat), o_rdata[k], e_rd[k]);
        checkOutput($sformatf("u%0d.mem_alu_result", lat), o_alu[k], e_alu[k]);
        checkOutput($sformatf("u%0d.mem_write_reg", lat), 32'(o_reg[k]), 32'(e_reg[k]));
      end
    end
  end

  task automatic applyStimulus(input int k, input stim_t s);
    @(posedge clk);
    #1;
    if (k == 0) s1 = s;
    else        s4 = s;
  endtask

  task automatic applyAccess(input int k, input stim_t s);
    applyStimulus(k, s);
    if (k == 1) repeat (3) @(posedge clk);
  endtask

  initial begin
    stim_t s;
    for (int k = 0; k < 2; k++) begin
      m_age[k] = 0;
      for (int i = 0; i < 256; i++) m_mem[k][i] = 32'd0;
    end
    s1 = idle_s();
    s1.rst = 1'b1; s1.memread = 1'b1; s1.branch = 1'b1; s1.zero = 1'b1;
    s4 = idle_s();
    s4.rst = 1'b1;

    @(posedge clk);
    check_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst.wb_ctlout", 32'(o_wb[0]), 32'd0);
    checkOutput("rst.read_data", o_rdata[0], 32'd0);
    checkOutput("rst.mem_alu_result", o_alu[0], 32'd0);
    checkOutput("rst.mem_write_reg", 32'(o_reg[0]), 32'd0);
    checkOutput("rst.mem_stall", 32'(o_stall[0]), 32'd0);
    checkOutput("rst.pcsrc", 32'(o_pcsrc[0]), 32'd0);

    // Single-cycle memory: store then load, wrap, read-during-write, pass-through.
    applyStimulus(0, st(32'h10, 32'hDEADBEEF));
    applyStimulus(0, ld(32'h10, 2'b11, 5'd7));
    applyStimulus(0, idle_s());
    @(negedge clk);
    checkOutput("sl.read_data", o_rdata[0], 32'hDEADBEEF);
    checkOutput("sl.wb_ctlout", 32'(o_wb[0]), 32'h3);
    checkOutput("sl.mem_write_reg", 32'(o_reg[0]), 32'd7);

    applyStimulus(0, st(32'h403, 32'hA5A5A5A5));
    applyStimulus(0, ld(32'h000, 2'b11, 5'd3));
    applyStimulus(0, idle_s());
    @(negedge clk);
    checkOutput("wrap.read_data", o_rdata[0], 32'hA5A5A5A5);

    applyStimulus(0, st(32'h20, 32'h00000001));
    s = st(32'h20, 32'h0BADF00D);
    s.memread = 1'b1;
    applyStimulus(0, s);
    applyStimulus(0, ld(32'h20, 2'b11, 5'd4));
    @(negedge clk);
    checkOutput("rw.old_data", o_rdata[0], 32'h00000001);
    applyStimulus(0, idle_s());
    @(negedge clk);
    checkOutput("rw.new_data", o_rdata[0], 32'h0BADF00D);

    s = idle_s();
    s.alu = 32'h1234; s.wb_ctl = 2'b10; s.rd = 5'd5;
    applyStimulus(0, s);
    applyStimulus(0, idle_s());
    @(negedge clk);
    checkOutput("pass.mem_alu_result", o_alu[0], 32'h1234);
    checkOutput("pass.wb_ctlout", 32'(o_wb[0]), 32'h2);

    s = idle_s();
    s.branch = 1'b1; s.zero = 1'b1; s.npc = 32'h100;
    applyStimulus(0, s);
    @(negedge clk);
    checkOutput("br.pcsrc_taken", 32'(o_pcsrc[0]), 32'd1);
    checkOutput("br.branch_target", o_target[0], 32'h100);
    checkOutput("br.no_stall", 32'(o_stall[0]), 32'd0);
    s.zero = 1'b0;
    applyStimulus(0, s);
    @(negedge clk);
    checkOutput("br.pcsrc_not_taken", 32'(o_pcsrc[0]), 32'd0);
    applyStimulus(0, idle_s());

    // Four-cycle memory: stall window, bubbles, back-to-back, reset abort.
    applyAccess(1, st(32'h0C, 32'h12345678));
    applyStimulus(1, ld(32'h0C, 2'b11, 5'd9));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ml.stall_%0d", i), 32'(o_stall[1]), 32'd1);
      checkOutput($sformatf("ml.bubble_%0d", i), 32'(o_wb[1]), 32'd0);
    end
    @(negedge clk);
    checkOutput("ml.commit_no_stall", 32'(o_stall[1]), 32'd0);
    applyStimulus(1, ld(32'h0C, 2'b01, 5'd2));
    @(negedge clk);
    checkOutput("ml.read_data", o_rdata[1], 32'h12345678);
    checkOutput("ml.wb_ctlout", 32'(o_wb[1]), 32'h3);
    checkOutput("b2b.restall", 32'(o_stall[1]), 32'd1);
    repeat (3) @(posedge clk);

    applyAccess(1, st(32'h14, 32'h11));
    applyStimulus(1, st(32'h14, 32'h55));
    @(posedge clk);
    #1;
    s4.rst = 1'b1;
    applyStimulus(1, idle_s());
    @(negedge clk);
    checkOutput("rstmid.stall", 32'(o_stall[1]), 32'd0);
    applyAccess(1, ld(32'h14, 2'b10, 5'd1));
    applyStimulus(1, idle_s());
    @(negedge clk);
    checkOutput("rstmid.read_data", o_rdata[1], 32'h11);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
